cc_cond_unit: RTL and testbench
===============================

Name: cc_cond_unit

Overview:
- Consumer of the execute-stage ALU's flag output.
- Holds the Y86-64 condition-code register (ZF/SF/OF) and updates it only for OPq instructions when no exception is in flight downstream.
- Evaluates the jXX/cmovXX condition to produce Cnd.
- Carries the execute result into the E->M pipeline register with stall/bubble control, including the cmov destination squash.

Parameters:
- WORD_W, 64, data path width of valE.
- REG_NONE, 4'hF, register ID meaning "no destination".

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- E_icode  in  4  execute-stage instruction code
- E_ifun  in  4  execute-stage function code
- E_stat  in  3  execute-stage status
- E_dstE  in  4  execute-stage destination register
- e_valE  in  WORD_W  ALU result
- CCnew  in  3  ALU flags: [2]=ZF, [1]=SF, [0]=OF
- m_stat  in  3  memory-stage status, current cycle
- W_stat  in  3  write-back-stage status
- M_stall  in  1  hold the M register
- M_bubble  in  1  load NOP into the M register
- CC  out  3  current condition codes, same bit order as CCnew
- e_Cnd  out  1  combinational condition result
- e_dstE  out  4  E_dstE, or REG_NONE for a cmov that is not taken
- M_icode  out  4  registered icode
- M_stat  out  3  registered status
- M_Cnd  out  1  registered Cnd
- M_dstE  out  4  registered destination
- M_valE  out  WORD_W  registered valE

Behaviour:
- Encodings:
  - icode: NOP=1, RRMOVQ=2, OPQ=6, JXX=7.
  - stat: AOK=1, HLT=2, ADR=3, INS=4.
- set_cc = (E_icode==OPQ) && m_stat==AOK && W_stat==AOK. It is independent of M_stall and M_bubble.
- CC register:
  - rst -> CC=3'b100 (ZF=1, SF=0, OF=0).
  - On a clock edge with set_cc, CC <= CCnew. Otherwise CC holds.
- e_Cnd is combinational from the registered CC, never from CCnew. An OPq and the following jXX/cmov therefore see a one-cycle dependency.
- Condition table, with ZF/SF/OF taken from CC:
  - ifun 0: 1.
  - ifun 1 (le): (SF^OF)|ZF.
  - ifun 2 (l): SF^OF.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): !ZF.
  - ifun 5 (ge): !(SF^OF).
  - ifun 6 (g): !(SF^OF)&!ZF.
  - ifun 7..15: 0.
- e_Cnd is evaluated for every icode. Downstream uses it only for JXX and RRMOVQ.
- e_dstE = REG_NONE when E_icode==RRMOVQ and !e_Cnd; otherwise E_dstE.
- M register update priority on each edge:
  1. rst: bubble state.
  2. M_stall: hold all M_* outputs.
  3. M_bubble: bubble state.
  4. Otherwise load {E_icode, E_stat, e_Cnd, e_dstE, e_valE}.
- Bubble state: M_icode=NOP, M_stat=AOK, M_Cnd=0, M_dstE=REG_NONE, M_valE=0.
- Reset values: CC=3'b100; M_* at bubble state.
- Latency:
  - CC update: 1 cycle.
  - e_Cnd and e_dstE: 0 cycles.
  - M_* outputs: 1 cycle.
- Boundary cases:
  - Simultaneous OPq update and jXX evaluation cannot occur; each stage holds one instruction.
  - With M_stall and set_cc both true, CC still updates. The pipeline control never asserts both.
  - rst asserted mid-stream overrides any pending set_cc on the same edge.

Optional Feature:
- Macro: COND_ILLEGAL_TRAP_EN.
- Defined:
  - E_icode in {JXX, RRMOVQ} with E_ifun>6 loads M_stat=INS instead of E_stat.
  - M_Cnd=0 and M_dstE=REG_NONE in that case.
- Undefined: such instructions load E_stat unchanged, with Cnd=0 per the table.

Decomposition:
- Shared package y86_pkg:
  - icode constants (NOP, RRMOVQ, OPQ, JXX).
  - stat constants (AOK, HLT, ADR, INS).
  - REG_NONE.
  - Condition ifun constants C_YES..C_G.
  - CC bit indices ZF_B=2, SF_B=1, OF_B=0.
- One sub-module, cond_eval:
  - Purely combinational: (CC, ifun) -> Cnd, plus an illegal flag.
  - Reused by the sequential variant of the processor.
- The CC register and the M register stay in cc_cond_unit.

Test Plan:
- Reset only:
  - After rst, expect CC=3'b100, M_icode=1, M_dstE=4'hF, M_valE=0.
  - jXX ifun=3 in E: e_Cnd=1. ifun=4: e_Cnd=0.
- OPq update:
  - Cycle 1: OPq with CCnew=3'b010, m_stat=W_stat=1.
  - Next cycle: CC=3'b010. jXX ifun=2 -> e_Cnd=1; ifun=1 -> 1; ifun=6 -> 0; ifun=5 -> 0.
- Update suppressed:
  - OPq with CCnew=3'b001 and m_stat=3: CC keeps its prior value.
  - Repeat with W_stat=2: CC still unchanged.
- Cmov squash:
  - CC=3'b000, RRMOVQ ifun=3, E_dstE=4'h3, e_valE=64'h5: e_dstE=4'hF.
  - Next edge: M_dstE=4'hF, M_Cnd=0, M_valE=5.
  - With ifun=4: M_dstE=3, M_Cnd=1.
- Stall/bubble:
  - Load valE=64'hAA, then hold M_stall for 2 cycles while E changes: M_valE stays AA.
  - M_stall and M_bubble together: hold.
  - M_bubble alone: bubble state next edge.
- Illegal ifun:
  - jXX ifun=9, E_stat=1 -> e_Cnd=0.
  - Next edge, M_stat=4 when COND_ILLEGAL_TRAP_EN is defined; M_stat=1 without it.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings, register IDs, condition codes and the E->M control payload.
package y86_pkg;

    localparam int unsigned ICODE_W = 4;
    localparam int unsigned IFUN_W  = 4;
    localparam int unsigned STAT_W  = 3;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned CC_W    = 3;

    // Instruction codes
    localparam logic [ICODE_W-1:0] I_NOP    = 4'h1;
    localparam logic [ICODE_W-1:0] I_RRMOVQ = 4'h2;
    localparam logic [ICODE_W-1:0] I_OPQ    = 4'h6;
    localparam logic [ICODE_W-1:0] I_JXX    = 4'h7;

    // Status codes
    localparam logic [STAT_W-1:0] S_AOK = 3'd1;
    localparam logic [STAT_W-1:0] S_HLT = 3'd2;
    localparam logic [STAT_W-1:0] S_ADR = 3'd3;
    localparam logic [STAT_W-1:0] S_INS = 3'd4;

    localparam logic [REG_W-1:0] REG_NONE = 4'hF;

    // Condition function codes for jXX / cmovXX
    localparam logic [IFUN_W-1:0] C_YES = 4'd0;
    localparam logic [IFUN_W-1:0] C_LE  = 4'd1;
    localparam logic [IFUN_W-1:0] C_L   = 4'd2;
    localparam logic [IFUN_W-1:0] C_E   = 4'd3;
    localparam logic [IFUN_W-1:0] C_NE  = 4'd4;
    localparam logic [IFUN_W-1:0] C_GE  = 4'd5;
    localparam logic [IFUN_W-1:0] C_G   = 4'd6;

    // Condition-code bit positions
    localparam int unsigned ZF_B = 2;
    localparam int unsigned SF_B = 1;
    localparam int unsigned OF_B = 0;

    localparam logic [CC_W-1:0] CC_RESET = 3'b100;

    // Control part of the M pipeline register (valE is carried separately, its width is a parameter)
    typedef struct packed {
        logic [ICODE_W-1:0] icode;
        logic [STAT_W-1:0]  stat;
        logic               cnd;
        logic [REG_W-1:0]   dste;
    } m_ctl_t;

    localparam m_ctl_t M_CTL_BUBBLE = '{icode: I_NOP, stat: S_AOK, cnd: 1'b0, dste: REG_NONE};

endpackage

// File: rtl/cond_eval.sv
// Combinational jXX/cmovXX condition evaluator.
// Ports: cc_i (ZF/SF/OF), ifun_i (condition code) -> cnd_o (condition holds),
//        illegal_o (ifun outside the defined condition set).
module cond_eval
    import y86_pkg::*;
(
    input  logic [CC_W-1:0]   cc_i,
    input  logic [IFUN_W-1:0] ifun_i,
    output logic              cnd_o,
    output logic              illegal_o
);

    logic zf;
    logic sf;
    logic of_f;
    logic lt;

    assign zf   = cc_i[ZF_B];
    assign sf   = cc_i[SF_B];
    assign of_f = cc_i[OF_B];
    assign lt   = sf ^ of_f;

    // Condition table; undefined function codes evaluate false
    always_comb begin
        cnd_o     = 1'b0;
        illegal_o = 1'b0;
        case (ifun_i)
            C_YES:   cnd_o = 1'b1;
            C_LE:    cnd_o = lt | zf;
            C_L:     cnd_o = lt;
            C_E:     cnd_o = zf;
            C_NE:    cnd_o = ~zf;
            C_GE:    cnd_o = ~lt;
            C_G:     cnd_o = ~lt & ~zf;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/cc_cond_unit.sv
// Y86-64 execute-stage condition-code register, jXX/cmov condition evaluation
// and E->M pipeline register with stall/bubble control.
// Optional feature macro: COND_ILLEGAL_TRAP_EN -- a jXX/cmov with an undefined
// condition function loads status INS into M (with Cnd=0, dstE=REG_NONE).
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   E_icode/ifun/stat/dstE execute-stage instruction fields
//   e_valE, CCnew          ALU result and ALU flags
//   m_stat, W_stat         downstream status, gate the CC update
//   M_stall, M_bubble      M register hold / NOP insert
//   CC                     current condition codes
//   e_Cnd, e_dstE          combinational condition and squashed destination
//   M_*                    registered E->M payload
module cc_cond_unit
    import y86_pkg::*;
#(
    parameter int unsigned WORD_W = 64
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic [ICODE_W-1:0]  E_icode,
    input  logic [IFUN_W-1:0]   E_ifun,
    input  logic [STAT_W-1:0]   E_stat,
    input  logic [REG_W-1:0]    E_dstE,
    input  logic [WORD_W-1:0]   e_valE,
    input  logic [CC_W-1:0]     CCnew,
    input  logic [STAT_W-1:0]   m_stat,
    input  logic [STAT_W-1:0]   W_stat,
    input  logic                M_stall,
    input  logic                M_bubble,
    output logic [CC_W-1:0]     CC,
    output logic                e_Cnd,
    output logic [REG_W-1:0]    e_dstE,
    output logic [ICODE_W-1:0]  M_icode,
    output logic [STAT_W-1:0]   M_stat,
    output logic                M_Cnd,
    output logic [REG_W-1:0]    M_dstE,
    output logic [WORD_W-1:0]   M_valE
);

    logic [CC_W-1:0]   cc_q;
    logic [CC_W-1:0]   cc_d;
    m_ctl_t            m_ctl_q;
    m_ctl_t            m_ctl_d;
    logic [WORD_W-1:0] m_vale_q;
    logic [WORD_W-1:0] m_vale_d;

    logic   cnd_raw;
    logic   cnd_illegal;
    logic   set_cc;
    m_ctl_t e_ctl;

    // Condition always comes from the registered flags, never from CCnew
    cond_eval u_cond_eval (
        .cc_i      (cc_q),
        .ifun_i    (E_ifun),
        .cnd_o     (cnd_raw),
        .illegal_o (cnd_illegal)
    );

    // The table already yields 0 for undefined codes; masking keeps that explicit
    assign e_Cnd  = cnd_raw & ~cnd_illegal;
    assign e_dstE = ((E_icode == I_RRMOVQ) && !e_Cnd) ? REG_NONE : E_dstE;
    assign set_cc = (E_icode == I_OPQ) && (m_stat == S_AOK) && (W_stat == S_AOK);

    // Payload that would be loaded into M this cycle
    always_comb begin
        e_ctl.icode = E_icode;
        e_ctl.stat  = E_stat;
        e_ctl.cnd   = e_Cnd;
        e_ctl.dste  = e_dstE;
`ifdef COND_ILLEGAL_TRAP_EN
        // Undefined condition on a jXX/cmov traps as an invalid instruction
        if (((E_icode == I_JXX) || (E_icode == I_RRMOVQ)) && cnd_illegal) begin
            e_ctl.stat = S_INS;
            e_ctl.cnd  = 1'b0;
            e_ctl.dste = REG_NONE;
        end
`endif
    end

    // CC update is independent of the M stall/bubble controls
    always_comb begin
        cc_d = cc_q;
        if (set_cc) begin
            cc_d = CCnew;
        end
    end

    // M register next state: stall beats bubble beats load
    always_comb begin
        m_ctl_d  = m_ctl_q;
        m_vale_d = m_vale_q;
        if (M_stall) begin
            m_ctl_d  = m_ctl_q;
            m_vale_d = m_vale_q;
        end else if (M_bubble) begin
            m_ctl_d  = M_CTL_BUBBLE;
            m_vale_d = '0;
        end else begin
            m_ctl_d  = e_ctl;
            m_vale_d = e_valE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q     <= CC_RESET;
            m_ctl_q  <= M_CTL_BUBBLE;
            m_vale_q <= '0;
        end else begin
            cc_q     <= cc_d;
            m_ctl_q  <= m_ctl_d;
            m_vale_q <= m_vale_d;
        end
    end

    assign CC      = cc_q;
    assign M_icode = m_ctl_q.icode;
    assign M_stat  = m_ctl_q.stat;
    assign M_Cnd   = m_ctl_q.cnd;
    assign M_dstE  = m_ctl_q.dste;
    assign M_valE  = m_vale_q;

endmodule

// File: tb/tb_cc_cond_unit.sv
// Scoreboard bench for cc_cond_unit: each step drives one set of execute-stage
// inputs, checks the combinational outputs, pushes the expected post-edge state
// and pops/compares it after the clock edge.
module tb_cc_cond_unit;

    localparam int unsigned W = 64;

    logic         clk;
    logic         rst;
    logic [3:0]   E_icode;
    logic [3:0]   E_ifun;
    logic [2:0]   E_stat;
    logic [3:0]   E_dstE;
    logic [W-1:0] e_valE;
    logic [2:0]   CCnew;
    logic [2:0]   m_stat;
    logic [2:0]   W_stat;
    logic         M_stall;
    logic         M_bubble;
    logic [2:0]   CC;
    logic         e_Cnd;
    logic [3:0]   e_dstE;
    logic [3:0]   M_icode;
    logic [2:0]   M_stat;
    logic         M_Cnd;
    logic [3:0]   M_dstE;
    logic [W-1:0] M_valE;

    cc_cond_unit #(.WORD_W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .E_icode  (E_icode),
        .E_ifun   (E_ifun),
        .E_stat   (E_stat),
        .E_dstE   (E_dstE),
        .e_valE   (e_valE),
        .CCnew    (CCnew),
        .m_stat   (m_stat),
        .W_stat   (W_stat),
        .M_stall  (M_stall),
        .M_bubble (M_bubble),
        .CC       (CC),
        .e_Cnd    (e_Cnd),
        .e_dstE   (e_dstE),
        .M_icode  (M_icode),
        .M_stat   (M_stat),
        .M_Cnd    (M_Cnd),
        .M_dstE   (M_dstE),
        .M_valE   (M_valE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   cc;
        logic [3:0]   icode;
        logic [2:0]   stat;
        logic         cnd;
        logic [3:0]   dste;
        logic [W-1:0] vale;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;      // model of the state currently held by the DUT
    int   total;
    int   bad;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference condition table
    function automatic logic ref_cnd(input logic [2:0] cc, input logic [3:0] ifun);
        logic zf, sf, ovf;
        zf  = cc[2];
        sf  = cc[1];
        ovf = cc[0];
        case (ifun)
            4'd0:    return 1'b1;
            4'd1:    return (sf ^ ovf) | zf;
            4'd2:    return sf ^ ovf;
            4'd3:    return zf;
            4'd4:    return !zf;
            4'd5:    return !(sf ^ ovf);
            4'd6:    return !(sf ^ ovf) & !zf;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step(input logic [3:0] icode, input logic [3:0] ifun, input logic [2:0] stat,
                        input logic [3:0] dste, input logic [W-1:0] vale, input logic [2:0] ccnew,
                        input logic [2:0] ms, input logic [2:0] ws,
                        input logic stall, input logic bubble, input logic r);
        logic       x_cnd;
        logic [3:0] x_dste;
        exp_t       nxt;
        exp_t       got;
        E_icode = icode; E_ifun = ifun; E_stat = stat; E_dstE = dste; e_valE = vale;
        CCnew = ccnew; m_stat = ms; W_stat = ws; M_stall = stall; M_bubble = bubble; rst = r;
        #1;
        x_cnd  = ref_cnd(cur.cc, ifun);
        x_dste = (icode == 4'h2 && !x_cnd) ? 4'hF : dste;
        check_eq("e_Cnd", 64'(e_Cnd), 64'(x_cnd));
        check_eq("e_dstE", 64'(e_dstE), 64'(x_dste));
        nxt = cur;
        if (r) begin
            nxt = '{cc: 3'b100, icode: 4'h1, stat: 3'd1, cnd: 1'b0, dste: 4'hF, vale: '0};
        end else begin
            if (icode == 4'h6 && ms == 3'd1 && ws == 3'd1) nxt.cc = ccnew;
            if (!stall) begin
                if (bubble) begin
                    nxt.icode = 4'h1; nxt.stat = 3'd1; nxt.cnd = 1'b0; nxt.dste = 4'hF; nxt.vale = '0;
                end else begin
                    nxt.icode = icode; nxt.stat = stat; nxt.cnd = x_cnd; nxt.dste = x_dste; nxt.vale = vale;
`ifdef COND_ILLEGAL_TRAP_EN
                    if ((icode == 4'h7 || icode == 4'h2) && ifun > 4'd6) begin
                        nxt.stat = 3'd4; nxt.cnd = 1'b0; nxt.dste = 4'hF;
                    end
`endif
                end
            end
        end
        exp_q.push_back(nxt);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check_eq("CC", 64'(CC), 64'(got.cc));
        check_eq("M_icode", 64'(M_icode), 64'(got.icode));
        check_eq("M_stat", 64'(M_stat), 64'(got.stat));
        check_eq("M_Cnd", 64'(M_Cnd), 64'(got.cnd));
        check_eq("M_dstE", 64'(M_dstE), 64'(got.dste));
        check_eq("M_valE", M_valE, got.vale);
        cur = got;
        @(negedge clk);
    endtask

    // Shorthands: OPq and jXX with everything else quiet
    task automatic opq(input logic [2:0] ccn, input logic [2:0] ms, input logic [2:0] ws);
        step(4'h6, 4'h0, 3'd1, 4'h4, 64'h11, ccn, ms, ws, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic jxx(input logic [3:0] ifun);
        step(4'h7, ifun, 3'd1, 4'hF, 64'h0, 3'b000, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; E_icode = 4'h1; E_ifun = 4'h0; E_stat = 3'd1; E_dstE = 4'hF; e_valE = '0;
        CCnew = 3'b000; m_stat = 3'd1; W_stat = 3'd1; M_stall = 1'b0; M_bubble = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cur = '{cc: 3'b100, icode: 4'h1, stat: 3'd1, cnd: 1'b0, dste: 4'hF, vale: '0};

        // Reset state, independent of the model
        check_eq("rst_CC", 64'(CC), 64'h4);
        check_eq("rst_M_icode", 64'(M_icode), 64'h1);
        check_eq("rst_M_dstE", 64'(M_dstE), 64'hF);
        check_eq("rst_M_valE", M_valE, 64'h0);
        check_eq("rst_M_stat", 64'(M_stat), 64'h1);
        check_eq("rst_M_Cnd", 64'(M_Cnd), 64'h0);

        jxx(4'd3);
        jxx(4'd4);

        // OPq update, then conditions against CC=010
        opq(3'b010, 3'd1, 3'd1);
        check_eq("cc_after_opq", 64'(CC), 64'h2);
        jxx(4'd2); jxx(4'd1); jxx(4'd6); jxx(4'd5);

        // Suppressed updates
        opq(3'b001, 3'd3, 3'd1);
        opq(3'b001, 3'd1, 3'd2);
        check_eq("cc_suppressed", 64'(CC), 64'h2);

        // Cmov squash with CC=000
        opq(3'b000, 3'd1, 3'd1);
        step(4'h2, 4'd3, 3'd1, 4'h3, 64'h5, 3'b000, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0);
        check_eq("cmov_nt_dstE", 64'(M_dstE), 64'hF);
        step(4'h2, 4'd4, 3'd1, 4'h3, 64'h5, 3'b000, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0);
        check_eq("cmov_t_dstE", 64'(M_dstE), 64'h3);

        // Stall / bubble
        step(4'h2, 4'd0, 3'd1, 4'h2, 64'hAA, 3'b000, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0);
        step(4'h1, 4'd0, 3'd1, 4'h7, 64'hBB, 3'b000, 3'd1, 3'd1, 1'b1, 1'b0, 1'b0);
        step(4'h2, 4'd0, 3'd2, 4'h8, 64'hCC, 3'b000, 3'd1, 3'd1, 1'b1, 1'b0, 1'b0);
        check_eq("stall_valE", M_valE, 64'hAA);
        step(4'h2, 4'd0, 3'd1, 4'h9, 64'hDD, 3'b000, 3'd1, 3'd1, 1'b1, 1'b1, 1'b0);
        check_eq("stall_bubble_valE", M_valE, 64'hAA);
        step(4'h2, 4'd0, 3'd1, 4'h9, 64'hEE, 3'b000, 3'd1, 3'd1, 1'b0, 1'b1, 1'b0);
        check_eq("bubble_icode", 64'(M_icode), 64'h1);

        // Illegal condition codes
        jxx(4'd9);
`ifdef COND_ILLEGAL_TRAP_EN
        check_eq("illegal_jxx_stat", 64'(M_stat), 64'h4);
`else
        check_eq("illegal_jxx_stat", 64'(M_stat), 64'h1);
`endif
        step(4'h2, 4'd12, 3'd1, 4'h5, 64'h77, 3'b000, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0);

        // Reset mid-stream beats a pending CC update
        step(4'h6, 4'd0, 3'd1, 4'h4, 64'h99, 3'b011, 3'd1, 3'd1, 1'b0, 1'b0, 1'b1);
        check_eq("rst_over_setcc", 64'(CC), 64'h4);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            logic [3:0] ic;
            case ($urandom_range(0, 3))
                0: ic = 4'h1;
                1: ic = 4'h2;
                2: ic = 4'h6;
                default: ic = 4'h7;
            endcase
            step(ic, 4'($urandom_range(0, 15)), 3'($urandom_range(1, 4)), 4'($urandom_range(0, 15)),
                 {32'($urandom), 32'($urandom)}, 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0) ? 3'd3 : 3'd1, ($urandom_range(0, 3) == 0) ? 3'd2 : 3'd1,
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
